// File: rtl/video_format_sequencer.sv
// Purpose : qualifies the detector format code over several fields, mutes the video path
//           during changes and issues one cfg_valid/cfg_ready transaction per qualified change.
// Latency : request registered one clk after the qualifying count is stored; mute follows next state.
// Backpressure: cfg_valid/cfg_format hold until cfg_ready; a handshake watchdog abandons the request.
//
// Ports:
//   clk, reset_x      system clock, asynchronous active-low reset
//   vsync_tick        one-cycle pulse per field (already in the clk domain)
//   format_in[7:0]    detector format code, 0x00 = none; sampled only on vsync_tick
//   cfg_ready         downstream accepts cfg_format while cfg_valid is high
//   cfg_valid         configuration request
//   cfg_format[7:0]   format code being configured
//   mute_out          1 = blank the video path
//   locked            1 = active format configured and settled
//   active_format     last format accepted downstream
//   cfg_error         sticky handshake-timeout flag, cleared by the next accepted handshake
//   state_out[2:0]    current state (debug)

module video_format_sequencer #(
    parameter int STABLE_FIELDS = 4,
    parameter int SETTLE_FIELDS = 8,
    parameter int CFG_TIMEOUT   = 1000000,
    parameter int VS_TIMEOUT    = 2000000
) (
    input  logic       clk,
    input  logic       reset_x,
    input  logic       vsync_tick,
    input  logic [7:0] format_in,
    input  logic       cfg_ready,
    output logic       cfg_valid,
    output logic [7:0] cfg_format,
    output logic       mute_out,
    output logic       locked,
    output logic [7:0] active_format,
    output logic       cfg_error,
    output logic [2:0] state_out
);

    localparam logic [2:0] ST_NOSIG   = 3'd0;
    localparam logic [2:0] ST_QUALIFY = 3'd1;
    localparam logic [2:0] ST_CONFIG  = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_LOCKED  = 3'd4;

    localparam logic [3:0]  STABLE_TH   = 4'(STABLE_FIELDS);
    localparam logic [7:0]  SETTLE_TH   = 8'(SETTLE_FIELDS);
    // Timeouts fire on the clock where the count reaches its limit, so the
    // comparison is made against limit-1 on the registered count.
    localparam logic [23:0] CFG_TO_LAST = 24'(CFG_TIMEOUT - 1);
    localparam logic [23:0] VS_TO_LAST  = 24'(VS_TIMEOUT - 1);
    localparam logic [23:0] VS_TO_MAX   = 24'(VS_TIMEOUT);

    logic [2:0]  state_q,         state_d;
    logic [7:0]  candidate_q,     candidate_d;
    logic [3:0]  stable_cnt_q,    stable_cnt_d;
    logic [23:0] vs_cnt_q,        vs_cnt_d;
    logic [23:0] to_cnt_q,        to_cnt_d;
    logic [7:0]  settle_cnt_q,    settle_cnt_d;
    logic        cfg_valid_q,     cfg_valid_d;
    logic [7:0]  cfg_format_q,    cfg_format_d;
    logic        mute_q,          mute_d;
    logic        locked_q,        locked_d;
    logic [7:0]  active_format_q, active_format_d;
    logic        cfg_error_q,     cfg_error_d;

    logic        qualified;
    logic        fmt_match;
    logic        fmt_change;
    logic        handshake;
    logic        vs_expire;
    logic [7:0]  settle_inc;

    always_comb begin
        state_d         = state_q;
        candidate_d     = candidate_q;
        stable_cnt_d    = stable_cnt_q;
        vs_cnt_d        = vs_cnt_q;
        to_cnt_d        = to_cnt_q;
        settle_cnt_d    = settle_cnt_q;
        cfg_valid_d     = cfg_valid_q;
        cfg_format_d    = cfg_format_q;
        active_format_d = active_format_q;
        cfg_error_d     = cfg_error_q;

        qualified  = (stable_cnt_q >= STABLE_TH);
        fmt_match  = vsync_tick && (format_in == active_format_q);
        fmt_change = vsync_tick && (format_in != active_format_q);
        handshake  = cfg_valid_q && cfg_ready;
        settle_inc = settle_cnt_q + 8'd1;

        // Format qualifier: independent of the control state.
        if (vsync_tick) begin
            if (format_in == candidate_q) begin
                if (stable_cnt_q != 4'hF) begin
                    stable_cnt_d = stable_cnt_q + 4'd1;
                end
            end else begin
                candidate_d  = format_in;
                stable_cnt_d = 4'd1;
            end
        end

        // Field watchdog. A tick in the current cycle cancels expiry so the
        // first field after a signal returns is not thrown away.
        if (vsync_tick) begin
            vs_cnt_d = 24'd0;
        end else if (vs_cnt_q < VS_TO_MAX) begin
            vs_cnt_d = vs_cnt_q + 24'd1;
        end
        vs_expire = !vsync_tick && (vs_cnt_q >= VS_TO_LAST);

        case (state_q)
            ST_NOSIG: begin
                if (vsync_tick && (format_in != 8'h00)) begin
                    state_d = ST_QUALIFY;
                end
            end

            ST_QUALIFY: begin
                if (qualified) begin
                    if (candidate_q == 8'h00) begin
                        state_d = ST_NOSIG;
                    end else if (candidate_q == active_format_q) begin
                        // Same format already configured downstream: only re-settle.
                        state_d      = ST_SETTLE;
                        settle_cnt_d = 8'd0;
                    end else begin
                        state_d      = ST_CONFIG;
                        cfg_valid_d  = 1'b1;
                        cfg_format_d = candidate_q;
                        to_cnt_d     = 24'd0;
                    end
                end
            end

            ST_CONFIG: begin
                // Handshake has priority over the timeout on the same clock.
                if (handshake) begin
                    active_format_d = cfg_format_q;
                    cfg_valid_d     = 1'b0;
                    cfg_error_d     = 1'b0;
                    settle_cnt_d    = 8'd0;
                    state_d         = ST_SETTLE;
                end else if (to_cnt_q >= CFG_TO_LAST) begin
                    cfg_valid_d  = 1'b0;
                    cfg_error_d  = 1'b1;
                    stable_cnt_d = 4'd0;
                    state_d      = ST_QUALIFY;
                end else begin
                    to_cnt_d = to_cnt_q + 24'd1;
                end
            end

            ST_SETTLE: begin
                if (fmt_change) begin
                    state_d = ST_QUALIFY;
                end else if (fmt_match) begin
                    settle_cnt_d = settle_inc;
                    if (settle_inc >= SETTLE_TH) begin
                        state_d = ST_LOCKED;
                    end
                end
            end

            ST_LOCKED: begin
                if (fmt_change) begin
                    state_d = ST_QUALIFY;
                end
            end

            default: begin
                state_d = ST_NOSIG;
            end
        endcase

        // Loss of field ticks overrides everything except the record of an
        // accepted handshake, which the downstream block has already acted on.
        if (vs_expire) begin
            state_d      = ST_NOSIG;
            candidate_d  = 8'h00;
            stable_cnt_d = 4'd0;
            cfg_valid_d  = 1'b0;
        end

        // Mute and lock derive from the next state so an unmuted field can
        // never carry a format other than the configured one.
        mute_d   = (state_d != ST_LOCKED);
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q         <= ST_NOSIG;
            candidate_q     <= 8'h00;
            stable_cnt_q    <= 4'd0;
            vs_cnt_q        <= 24'd0;
            to_cnt_q        <= 24'd0;
            settle_cnt_q    <= 8'd0;
            cfg_valid_q     <= 1'b0;
            cfg_format_q    <= 8'h00;
            mute_q          <= 1'b1;
            locked_q        <= 1'b0;
            active_format_q <= 8'h00;
            cfg_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            candidate_q     <= candidate_d;
            stable_cnt_q    <= stable_cnt_d;
            vs_cnt_q        <= vs_cnt_d;
            to_cnt_q        <= to_cnt_d;
            settle_cnt_q    <= settle_cnt_d;
            cfg_valid_q     <= cfg_valid_d;
            cfg_format_q    <= cfg_format_d;
            mute_q          <= mute_d;
            locked_q        <= locked_d;
            active_format_q <= active_format_d;
            cfg_error_q     <= cfg_error_d;
        end
    end

    assign cfg_valid     = cfg_valid_q;
    assign cfg_format    = cfg_format_q;
    assign mute_out      = mute_q;
    assign locked        = locked_q;
    assign active_format = active_format_q;
    assign cfg_error     = cfg_error_q;
    assign state_out     = state_q;

endmodule

// File: doc/video_format_sequencer.md
Name: video_format_sequencer

Overview:
- Controller between the sync-based video format detector and the downstream video-path configuration interface.
- Qualifies the detector's 8-bit format code over several fields before acting on it.
- Mutes the output while a format change is in progress.
- Issues one valid/ready configuration transaction per qualified change, then holds mute through a settle period before reporting lock.
- Watchdogs the vsync field tick and times out the configuration handshake.

Parameters:
- STABLE_FIELDS, 4: consecutive identical format samples required to qualify a format (range 1..15).
- SETTLE_FIELDS, 8: vsync ticks that mute is held after a configuration is accepted (range 1..255).
- CFG_TIMEOUT, 1000000: clocks to wait for cfg_ready before declaring a fault (counter 24 bits).
- VS_TIMEOUT, 2000000: clocks without vsync_tick before declaring no signal (counter 24 bits).

Ports:
- clk  in  1  system clock (25 MHz domain).
- reset_x  in  1  reset, asynchronous, active-low.
- vsync_tick  in  1  single-cycle pulse per field, already synchronised to clk.
- format_in  in  8  detector format code; 0x00 = none/invalid. Sampled only on vsync_tick.
- cfg_ready  in  1  downstream accepts cfg_format while cfg_valid=1.
- cfg_valid  out  1  configuration request.
- cfg_format  out  8  format code being configured.
- mute_out  out  1  1 = blank/mute the video path.
- locked  out  1  1 = active format configured and settled.
- active_format  out  8  last format accepted by the downstream block.
- cfg_error  out  1  sticky; set on handshake timeout, cleared on the next accepted handshake.
- state_out  out  3  current state encoding (debug).

Behaviour:
- Reset values (async on reset_x low): state NOSIG, cfg_valid 0, cfg_format 0x00, mute_out 1, locked 0, active_format 0x00, cfg_error 0, all counters 0, candidate 0x00.
- State encodings: NOSIG=0, QUALIFY=1, CONFIG=2, SETTLE=3, LOCKED=4.
- Qualifier runs in every state, on vsync_tick only:
  - format_in == candidate: stable_cnt increments, saturating at 15.
  - Otherwise: candidate <= format_in, stable_cnt <= 1.
  - qualified = (stable_cnt >= STABLE_FIELDS), evaluated on registered values.
- Vsync watchdog:
  - vs_cnt clears on vsync_tick, otherwise increments, saturating.
  - vs_cnt reaching VS_TIMEOUT in any state: next state NOSIG, candidate <= 0x00, stable_cnt <= 0, cfg_valid <= 0. active_format and cfg_error are kept.
- NOSIG: mute 1, locked 0. Go to QUALIFY on the first vsync_tick with format_in != 0x00.
- QUALIFY: mute 1, locked 0. When qualified:
  - candidate == 0x00: go to NOSIG.
  - candidate == active_format: go to SETTLE; no reconfiguration.
  - Otherwise: go to CONFIG, with cfg_format <= candidate and cfg_valid <= 1 registered on the transition (visible the cycle after qualification).
- CONFIG: mute 1.
  - cfg_valid and cfg_format are held stable until the handshake cycle (cfg_valid & cfg_ready).
  - On handshake: active_format <= cfg_format, cfg_valid <= 0, cfg_error <= 0, settle_cnt <= 0, go to SETTLE.
  - to_cnt counts clocks in CONFIG. Reaching CFG_TIMEOUT: cfg_valid <= 0, cfg_error <= 1, stable_cnt <= 0, go to QUALIFY.
  - Handshake and timeout in the same cycle: handshake wins.
  - A vsync_tick carrying a new format during CONFIG does not abort the transaction; it only updates the qualifier, and the change is handled from SETTLE.
- SETTLE: mute 1.
  - Each vsync_tick with format_in == active_format increments settle_cnt.
  - Any vsync_tick with format_in != active_format: go to QUALIFY.
  - settle_cnt reaching SETTLE_FIELDS: go to LOCKED.
- LOCKED: mute 0, locked 1.
  - vsync_tick with format_in != active_format: go to QUALIFY with mute 1 and locked 0 in that same transition cycle (no unmuted field with a wrong format).
- mute_out and locked are registered and mutually exclusive at all times.
- Reset mid-handshake: cfg_valid drops immediately (async). Downstream must tolerate an abandoned request.

Test Plan:
- Lock from reset: format_in=0x01 with ticks every 1000 clk; cfg_ready asserted 3 clk after cfg_valid rises.
  - Required: cfg_valid rises 1 clk after the 4th tick, with cfg_format=0x01.
  - Required: handshake gives active_format=0x01 and SETTLE.
  - Required: after 8 further ticks, locked=1 and mute_out=0.
- Format change while locked at 0x01: format_in becomes 0x03.
  - Required: on that tick, mute_out=1 and locked=0 in the same transition.
  - Required: after 4 ticks at 0x03, cfg_format=0x03.
  - Required: after handshake + 8 ticks, locked with active_format=0x03.
- Glitch: while locked at 0x01, one tick at 0x0B, then back to 0x01.
  - Required: mute during the glitch; after 4 ticks at 0x01, go straight to SETTLE with no cfg_valid; relock after 8 ticks.
- Handshake timeout: cfg_ready held 0.
  - Required: cfg_valid held for exactly CFG_TIMEOUT clk, then drops; cfg_error=1; state QUALIFY.
  - Required: after requalification, cfg_valid reasserts; a ready then clears cfg_error.
- Loss of sync: stop vsync_tick while locked.
  - Required: after VS_TIMEOUT clk, state NOSIG, mute_out=1, locked=0, active_format retained.
  - Also check: handshake and timeout in the same cycle gives SETTLE with cfg_error=0.
- Async reset asserted during CONFIG with cfg_valid=1.
  - Required: cfg_valid=0, mute_out=1, state NOSIG immediately, without waiting for a clk edge.
